alignment_fill_controller: RTL

Sequences a single external `cell_calculator` over a full alignment matrix (Needleman-Wunsch global fill), one cell per clock in row-major order. It holds both 2-bit-encoded sequences and one row of scores, selects match/mismatch per cell, and feeds the diagonal/up/left neighbours to the calculator. It registers each returned score and writes every returned direction to an external traceback memory. It sits between the sequence loader and the traceback unit.

---
 rtl/alignment_fill_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/alignment_fill_controller.sv
// alignment_fill_controller: drives one external cell_calculator over a Needleman-Wunsch matrix, one cell per clock.
// Ports: seq_* load bases (IDLE only); len_*, *_score, gap_penalty are sampled on start; busy/done/final_score report the run;
// calc_* feed the calculator and take back calc_score/calc_dir; tb_* write each cell's direction to traceback memory.
// Define LOCAL_ALIGN_EN for Smith-Waterman mode (zero floor, dir 11, max tracking on max_row/max_col).
module alignment_fill_controller #(
  parameter int MAX_LEN = 16,
  parameter int SCORE_W = 8,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic seq_we,
  input  logic seq_sel,
  input  logic [LEN_W-1:0] seq_addr,
  input  logic [1:0] seq_data,
  input  logic [LEN_W-1:0] len_a,
  input  logic [LEN_W-1:0] len_b,
  input  logic signed [SCORE_W-1:0] match_score,
  input  logic signed [SCORE_W-1:0] mismatch_score,
  input  logic signed [SCORE_W-1:0] gap_penalty,
  input  logic start,
  output logic busy,
  output logic done,
  output logic signed [SCORE_W-1:0] final_score,
  output logic signed [SCORE_W-1:0] calc_diag,
  output logic signed [SCORE_W-1:0] calc_up,
  output logic signed [SCORE_W-1:0] calc_left,
  output logic signed [SCORE_W-1:0] calc_match,
  output logic signed [SCORE_W-1:0] calc_gap,
  input  logic signed [SCORE_W-1:0] calc_score,
  input  logic [1:0] calc_dir,
  output logic tb_we,
  output logic [LEN_W-1:0] tb_row,
  output logic [LEN_W-1:0] tb_col,
  output logic [1:0] tb_dir
`ifdef LOCAL_ALIGN_EN
  ,
  output logic [LEN_W-1:0] max_row,
  output logic [LEN_W-1:0] max_col
`endif
);
`ifdef LOCAL_ALIGN_EN
  localparam bit LOCAL = 1'b1;
`else
  localparam bit LOCAL = 1'b0;
`endif
  localparam int PW = SCORE_W + LEN_W + 2;
  localparam logic signed [PW-1:0] SMAX = PW'((2 ** (SCORE_W - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN = PW'(-(2 ** (SCORE_W - 1)));
  typedef enum logic [1:0] {IDLE, INIT, FILL, DONE} state_t;
  state_t state;
  logic [1:0] seq_a [0:MAX_LEN];
  logic [1:0] seq_b [0:MAX_LEN];
  logic signed [SCORE_W-1:0] row [0:MAX_LEN];
  logic signed [SCORE_W-1:0] match, mismatch, gap, diag, left, bound, score, fin;
  logic [LEN_W-1:0] la, lb, i, j;
  logic fill, first, last;
  function automatic logic signed [SCORE_W-1:0] sat(input logic signed [PW-1:0] v);
    return v > SMAX ? SMAX[SCORE_W-1:0] : v < SMIN ? SMIN[SCORE_W-1:0] : v[SCORE_W-1:0];
  endfunction
  function automatic logic signed [SCORE_W-1:0] sat_mul(input logic [LEN_W:0] k, input logic signed [SCORE_W-1:0] g);
    return sat(PW'(signed'({1'b0, k})) * PW'(g));
  endfunction
  assign fill = state == FILL;
  assign first = j == LEN_W'(1);
  assign last = i == lb && j == la;
  // row[0] holds the boundary column H(i-1,0); the left neighbour of column 1 is one gap further down
  assign bound = LOCAL ? '0 : sat(PW'(row[0]) + PW'(gap));
  assign score = LOCAL && calc_score[SCORE_W-1] ? '0 : calc_score;
  always_comb begin
    calc_diag = fill ? (first ? row[0] : diag) : '0;
    calc_up = fill ? row[j] : '0;
    calc_left = fill ? (first ? bound : left) : '0;
    calc_match = !fill ? '0 : seq_a[j - 1'b1] == seq_b[i - 1'b1] ? match : mismatch;
    calc_gap = fill ? gap : '0;
    tb_we = fill;
    tb_row = fill ? i : '0;
    tb_col = fill ? j : '0;
    tb_dir = !fill ? 2'b00 : LOCAL && calc_score[SCORE_W-1] ? 2'b11 : calc_dir;
  end
  always_ff @(posedge clk)
    if (seq_we && state == IDLE && seq_addr < LEN_W'(MAX_LEN)) begin
      if (seq_sel) seq_b[seq_addr] <= seq_data;
      else seq_a[seq_addr] <= seq_data;
    end
`ifdef LOCAL_ALIGN_EN
  logic signed [SCORE_W-1:0] mx;
  logic upd;
  assign upd = (i == LEN_W'(1) && first) || score > mx;
  assign fin = upd ? score : mx;
  always_ff @(posedge clk)
    if (rst || (state == IDLE && start)) begin
      mx <= '0;
      max_row <= '0;
      max_col <= '0;
    end else if (fill && upd) begin
      mx <= score;
      max_row <= i;
      max_col <= j;
    end
`else
  assign fin = score;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      final_score <= '0;
      i <= '0;
      j <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= INIT;
          busy <= 1'b1;
          la <= len_a > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len_a;
          lb <= len_b > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : len_b;
          match <= match_score;
          mismatch <= mismatch_score;
          gap <= gap_penalty;
        end
        INIT: begin
          for (int k = 0; k <= MAX_LEN; k++) row[k] <= LOCAL ? '0 : sat_mul((LEN_W + 1)'(k), gap);
          i <= LEN_W'(1);
          j <= LEN_W'(1);
          if (la == '0 || lb == '0) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            final_score <= LOCAL ? '0 : sat_mul({1'b0, la} + {1'b0, lb}, gap);
          end else state <= FILL;
        end
        FILL: begin
          row[j] <= score;
          left <= score;
          diag <= row[j];
          if (first) row[0] <= bound;
          j <= j == la ? LEN_W'(1) : j + 1'b1;
          if (j == la) i <= i + 1'b1;
          if (last) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            final_score <= fin;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
endmodule
